quad_encoder_io: RTL and testbench
==================================

QUAD_ENCODER_IO -- requirements
Module: quad_encoder_io

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100, the consecutive stable cycles a synchronized encoder input needs before its filtered value updates (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port IOinsn, input, 1, CPU memory-mapped IO access strobe (one cycle).
REQ-005 SHALL have port IOwrite, input, 1, meaningful only with IOinsn: 1 = SW, 0 = LW.
REQ-006 SHALL have port memAddr, input, 32, CPU address.
REQ-007 SHALL have port dataIn, input, 32, SW data.
REQ-008 SHALL have port dataOut, output, 32, registered LW data.
REQ-009 SHALL have port JB, input, 3, encoder pins: JB[0]=A, JB[1]=B, JB[2]=index (index used only with ENC_INDEX_EN).

Function
REQ-010 SHALL select the block when IOinsn && memAddr[13]; register offset = memAddr[3:2].
REQ-011 SHALL pass each JB bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL, per channel, update the filtered value only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the filtered value restarts that channel's count.
REQ-013 SHALL run a decoder FSM with states INIT and TRACK; reset enters INIT.
REQ-014 SHALL, in INIT, wait DEBOUNCE_CYCLES+3 cycles, then load prev={A,B} from the filtered values and enter TRACK without counting.
REQ-015 SHALL, in TRACK, compare prev to filtered {A,B} every cycle: forward sequence 00->01->11->10->00 adds +1; reverse sequence subtracts 1; no change does nothing; both bits changing sets sticky error and leaves count unchanged; prev updates every cycle.
REQ-016 SHALL keep count as a 32-bit two's-complement value wrapping silently (0x7FFFFFFF+1 = 0x80000000; 0-1 = 0xFFFFFFFF).
REQ-017 SHALL set sticky moved on any counted step and record dir (1 = last step forward).
REQ-018 SHALL, on an LW to offset 0/1/2/3, drive dataOut on the next clock edge with count / status {28'b0, idx_flag, dir, error, moved} / {30'b0, B_filt, A_filt} / index register; dataOut holds its value between reads.
REQ-019 SHALL, on an SW to offset 0, load count with dataIn; a same-cycle encoder step is discarded.
REQ-020 SHALL, on an SW to offset 1, clear moved, error and idx_flag wherever the corresponding dataIn bits [0], [1] and [3] are 1; a same-cycle set event wins over the clear.
REQ-021 SHALL ignore SW to offsets 2 and 3 and all accesses while the block is not selected.

Reset
REQ-022 SHALL, with reset high at a clock edge, clear count, index register, moved, dir, error, idx_flag, filtered values, debounce counters, synchronizers and dataOut to 0, and enter INIT.
REQ-023 SHALL abandon any in-progress debounce or pending step when reset is asserted mid-operation; the block SHALL NOT count until it reaches TRACK again.

Configuration
REQ-024 SHALL, with ENC_INDEX_EN defined, debounce JB[2] like A/B; on a filtered index rising edge in TRACK, copy count (after that cycle's step) into the index register and set sticky idx_flag.
REQ-025 SHALL, without ENC_INDEX_EN, ignore JB[2], read the index register as 0 and hold idx_flag at 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Hold A/B=00 through INIT, then apply 4 forward steps held 10 cycles each -> LW offset 0 returns 4 and status 0x5.
REQ-027 Apply a 3-cycle glitch on A -> count unchanged and moved=0.
REQ-028 In TRACK, move A/B from 00 to 11 in one cycle -> error=1 and count unchanged; SW offset 1 dataIn=0x2 -> error=0.
REQ-029 SW offset 0 dataIn=0x7FFFFFFF, then one forward step -> read 0x80000000; SW 0 then one reverse step -> read 0xFFFFFFFF.
REQ-030 SW offset 0 in the same cycle as a filtered step -> count equals dataIn; assert reset mid-debounce -> all reads return 0.
REQ-031 With ENC_INDEX_EN and count=7, pulse index -> offset 3 reads 7 and status bit 3 = 1; without the macro, offset 3 reads 0.

Source files
------------

// File: rtl/quad_encoder_io.sv
// Quadrature encoder with debounced A/B (and index when ENC_INDEX_EN is defined), exposed as four CPU IO registers.
// LW data appears one clock after the strobe; there is no backpressure, and every access completes in its strobe cycle.
module quad_encoder_io #(
    parameter int DEBOUNCE_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IOinsn,
    input  logic        IOwrite,
    input  logic [31:0] memAddr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    input  logic [2:0]  JB
);

`ifdef ENC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    typedef enum logic {INIT, TRACK} state_t;

    state_t           state_q, state_d;
    logic [NCH-1:0]   sync1_q, sync2_q;
    logic [NCH-1:0]   filt_q, filt_d;
    logic [15:0]      db_cnt_q [NCH];
    logic [15:0]      db_cnt_d [NCH];
    logic [16:0]      init_cnt_q, init_cnt_d;
    logic [1:0]       prev_q, prev_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      idx_reg_q, idx_reg_d;
    logic             moved_q, moved_d;
    logic             dir_q, dir_d;
    logic             error_q, error_d;
    logic             idx_flag_q, idx_flag_d;
    logic             idx_prev_q, idx_prev_d;
    logic [31:0]      dout_q, dout_d;

    logic             sel, wr_cnt, wr_st, rd;
    logic [1:0]       off;
    logic [1:0]       cur;
    logic             step_fwd, step_rev, step_err;
    logic             idx_filt;
    logic             unused_bits;

`ifdef ENC_INDEX_EN
    assign idx_filt    = filt_q[2];
    assign unused_bits = ^{memAddr[31:14], memAddr[12:4], memAddr[1:0]};
`else
    assign idx_filt    = 1'b0;
    assign unused_bits = ^{memAddr[31:14], memAddr[12:4], memAddr[1:0], JB[2]};
`endif

    assign sel     = IOinsn && memAddr[13];
    assign off     = memAddr[3:2];
    assign wr_cnt  = sel && IOwrite && (off == 2'd0);
    assign wr_st   = sel && IOwrite && (off == 2'd1);
    assign rd      = sel && !IOwrite;
    assign cur     = {filt_q[0], filt_q[1]};
    assign dataOut = dout_q;

    // Per-channel debounce: the filtered value moves only after a full run of disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NCH; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // {A,B} forward cycle is 00 -> 01 -> 11 -> 10 -> 00.
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        step_err = 1'b0;
        case ({prev_q, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        count_d    = count_q;
        idx_reg_d  = idx_reg_q;
        moved_d    = moved_q;
        dir_d      = dir_q;
        error_d    = error_q;
        idx_flag_d = idx_flag_q;
        idx_prev_d = idx_filt;
        dout_d     = dout_q;

        if (wr_st) begin
            if (dataIn[0]) moved_d    = 1'b0;
            if (dataIn[1]) error_d    = 1'b0;
            if (dataIn[3]) idx_flag_d = 1'b0;
        end

        case (state_q)
            INIT: begin
                if (init_cnt_q == 17'(DEBOUNCE_CYCLES + 2)) begin
                    state_d    = TRACK;
                    prev_d     = cur;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 17'd1;
                end
            end
            TRACK: begin
                prev_d = cur;
                // A CPU load of the count swallows any step landing in the same cycle.
                if (!wr_cnt && (step_fwd || step_rev)) begin
                    count_d = step_fwd ? count_q + 32'd1 : count_q - 32'd1;
                    moved_d = 1'b1;
                    dir_d   = step_fwd;
                end
                if (step_err) error_d = 1'b1;
            end
            default: state_d = INIT;
        endcase

        if (wr_cnt) count_d = dataIn;

        if ((state_q == TRACK) && idx_filt && !idx_prev_q) begin
            idx_reg_d  = count_d;
            idx_flag_d = 1'b1;
        end

        if (rd) begin
            case (off)
                2'd0:    dout_d = count_q;
                2'd1:    dout_d = {28'b0, idx_flag_q, dir_q, error_q, moved_q};
                2'd2:    dout_d = {30'b0, filt_q[1], filt_q[0]};
                default: dout_d = idx_reg_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            init_cnt_q <= '0;
            prev_q     <= '0;
            count_q    <= '0;
            idx_reg_q  <= '0;
            moved_q    <= 1'b0;
            dir_q      <= 1'b0;
            error_q    <= 1'b0;
            idx_flag_q <= 1'b0;
            idx_prev_q <= 1'b0;
            dout_q     <= '0;
            for (int i = 0; i < NCH; i++) db_cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= JB[NCH-1:0];
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            idx_reg_q  <= idx_reg_d;
            moved_q    <= moved_d;
            dir_q      <= dir_d;
            error_q    <= error_d;
            idx_flag_q <= idx_flag_d;
            idx_prev_q <= idx_prev_d;
            dout_q     <= dout_d;
            for (int i = 0; i < NCH; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

endmodule

// File: tb/tb_quad_encoder_io.sv
// Directed bench for quad_encoder_io with DEBOUNCE_CYCLES=4; index checks follow ENC_INDEX_EN.
module tb_quad_encoder_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        IOinsn;
    logic        IOwrite;
    logic [31:0] memAddr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [2:0]  JB;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdat;

    quad_encoder_io #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .IOinsn  (IOinsn),
        .IOwrite (IOwrite),
        .memAddr (memAddr),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .JB      (JB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sw_addr(input logic [31:0] addr, input logic [31:0] d);
        IOinsn  = 1'b1;
        IOwrite = 1'b1;
        memAddr = addr;
        dataIn  = d;
        @(negedge clk);
        IOinsn  = 1'b0;
        IOwrite = 1'b0;
    endtask

    task automatic sw(input logic [1:0] off, input logic [31:0] d);
        sw_addr(32'h0000_2000 | {28'd0, off, 2'b00}, d);
    endtask

    task automatic lw(input logic [1:0] off, output logic [31:0] d);
        IOinsn  = 1'b1;
        IOwrite = 1'b0;
        memAddr = 32'h0000_2000 | {28'd0, off, 2'b00};
        @(negedge clk);
        IOinsn  = 1'b0;
        d       = dataOut;
    endtask

    initial begin
        reset   = 1'b1;
        IOinsn  = 1'b0;
        IOwrite = 1'b0;
        memAddr = '0;
        dataIn  = '0;
        JB      = 3'b000;
        tick(3);
        chk("reset_dout", dataOut, 32'h0);
        reset = 1'b0;
        lw(0, rdat); chk("reset_count", rdat, 32'h0);
        lw(1, rdat); chk("reset_status", rdat, 32'h0);
        lw(2, rdat); chk("reset_pins", rdat, 32'h0);
        lw(3, rdat); chk("reset_index", rdat, 32'h0);
        tick(20);

        // Four forward steps: {A,B} 00->01->11->10->00 (JB[0]=A, JB[1]=B).
        JB = 3'b010; tick(10);
        JB = 3'b011; tick(10);
        JB = 3'b001; tick(10);
        JB = 3'b000; tick(10);
        lw(0, rdat); chk("fwd4_count", rdat, 32'd4);
        lw(1, rdat); chk("fwd4_status", rdat, 32'h5);

        sw(1, 32'h1);
        JB = 3'b001; tick(3);
        JB = 3'b000; tick(10);
        lw(0, rdat); chk("glitch_count", rdat, 32'd4);
        lw(1, rdat); chk("glitch_status", rdat, 32'h4);
        lw(2, rdat); chk("glitch_pins", rdat, 32'h0);

        JB = 3'b011; tick(10);
        lw(1, rdat); chk("err_status", rdat, 32'h6);
        lw(0, rdat); chk("err_count", rdat, 32'd4);
        lw(2, rdat); chk("err_pins", rdat, 32'h3);
        sw(1, 32'h2);
        lw(1, rdat); chk("err_clear", rdat, 32'h4);

        JB = 3'b001; tick(10);
        JB = 3'b000; tick(10);
        lw(0, rdat); chk("after_err_count", rdat, 32'd6);
        tick(3);
        chk("dout_hold", dataOut, 32'd6);

        sw_addr(32'h0000_0000, 32'h123);
        sw(2, 32'h123);
        sw(3, 32'h123);
        lw(0, rdat); chk("ignored_writes", rdat, 32'd6);

        sw(0, 32'h7FFF_FFFF);
        JB = 3'b010; tick(10);
        lw(0, rdat); chk("wrap_pos", rdat, 32'h8000_0000);
        sw(0, 32'h0);
        JB = 3'b000; tick(10);
        lw(0, rdat); chk("wrap_neg", rdat, 32'hFFFF_FFFF);
        lw(1, rdat); chk("rev_status", rdat, 32'h1);

        // Step reaches the counter 6 cycles after the pin change (2 sync + 4 debounce).
        JB = 3'b010;
        tick(6);
        sw(0, 32'h55);
        lw(0, rdat); chk("sw_vs_step", rdat, 32'h55);
        tick(10);
        lw(0, rdat); chk("sw_vs_step_late", rdat, 32'h55);

        JB = 3'b011; tick(3);
        reset = 1'b1;
        JB    = 3'b000;
        tick(2);
        reset = 1'b0;
        lw(0, rdat); chk("midrst_count", rdat, 32'h0);
        lw(1, rdat); chk("midrst_status", rdat, 32'h0);
        lw(2, rdat); chk("midrst_pins", rdat, 32'h0);
        lw(3, rdat); chk("midrst_index", rdat, 32'h0);
        tick(20);
        lw(0, rdat); chk("midrst_settled", rdat, 32'h0);

        sw(0, 32'd7);
        JB = 3'b100; tick(10);
        JB = 3'b000; tick(10);
`ifdef ENC_INDEX_EN
        lw(3, rdat); chk("index_reg", rdat, 32'd7);
        lw(1, rdat); chk("index_status", rdat, 32'h8);
        sw(1, 32'h8);
        lw(1, rdat); chk("index_clear", rdat, 32'h0);
`else
        lw(3, rdat); chk("index_reg", rdat, 32'd0);
        lw(1, rdat); chk("index_status", rdat, 32'h0);
`endif
        lw(0, rdat); chk("index_count", rdat, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
